aes_iter_core: RTL and testbench

- Iterative AES-encrypt engine: one 16-byte block through NR rounds, one round per clock.
- Uses a single round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey, plus final-round bypass of MixColumns).
- Round keys are fetched by index from an external key store (key schedule lives outside this block).
- Sits between the host block interface and the key memory; replaces chaining NR combinational round instances.

---
 rtl/aes_iter_core.sv | 159 +++++++++++++++
 tb/tb_aes_iter_core.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_core.sv
// Iterative AES-encrypt core: one round per clock through a single shared round datapath.
// Optional macro AES_ZEROIZE_EN clears the state register on abort and on output handshake.
module aes_iter_core #(
  parameter int unsigned NR    = 10,
  parameter int unsigned RKI_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0][3:0][7:0] in_data,
  input  logic                 abort,
  output logic [RKI_W-1:0]     rk_idx,
  input  logic [3:0][3:0][7:0] rk,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0][3:0][7:0] out_data,
  output logic                 busy
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_iter_core: NR must be 10, 12 or 14");
  end
  if ((2 ** RKI_W) <= NR) begin : g_bad_rki_w
    $error("aes_iter_core: RKI_W too narrow for NR");
  end

  // Flattened block reads as the FIPS-197 hex string: byte n (n = 4*col + row) is b[15-n].
  typedef logic [15:0][7:0] blk_t;

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StHold} state_e;

  localparam logic [RKI_W-1:0] LastRound = RKI_W'(NR - 1);
  localparam logic [RKI_W-1:0] FinalIdx  = RKI_W'(NR);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254 by square-and-multiply) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a240, inv;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a240 = a15;
    for (int i = 0; i < 4; i++) a240 = gf_mul(a240, a240);
    inv  = gf_mul(gf_mul(a240, a12), a2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic blk_t aes_round(input blk_t s, input blk_t k, input logic last);
    logic [15:0][7:0] sb;
    logic [15:0][7:0] sr;
    logic [15:0][7:0] mc;
    blk_t             o;
    for (int n = 0; n < 16; n++) sb[n] = sbox(s[15-n]);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int n = 0; n < 16; n++) o[15-n] = (last ? sr[n] : mc[n]) ^ k[15-n];
    return o;
  endfunction

  state_e           st_q, st_d;
  logic [RKI_W-1:0] cnt_q, cnt_d;
  blk_t             blk_q, blk_d;
  blk_t             rnd_out;

  assign rnd_out  = aes_round(blk_q, rk, st_q == StFinal);
  assign out_data = blk_q;

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    blk_d     = blk_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = '0;
    unique case (st_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          blk_d = in_data ^ rk;
          cnt_d = RKI_W'(1);
          st_d  = StRound;
        end
      end
      StRound: begin
        busy   = 1'b1;
        rk_idx = cnt_q;
        blk_d  = rnd_out;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastRound) st_d = StFinal;
      end
      StFinal: begin
        busy   = 1'b1;
        rk_idx = FinalIdx;
        blk_d  = rnd_out;
        st_d   = StHold;
      end
      StHold: begin
        out_valid = 1'b1;
        if (out_ready) begin
          st_d  = StIdle;
          cnt_d = '0;
`ifdef AES_ZEROIZE_EN
          blk_d = '0;
`endif
        end
      end
    endcase
    // Abort overrides any in-flight round or handshake; it has no effect in IDLE.
    if (abort && st_q != StIdle) begin
      st_d  = StIdle;
      cnt_d = '0;
`ifdef AES_ZEROIZE_EN
      blk_d = '0;
`else
      blk_d = blk_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= StIdle;
      cnt_q <= '0;
      blk_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      blk_q <= blk_d;
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Self-checking bench for aes_iter_core: an NR=10 and an NR=14 instance against a byte-level
// AES reference model (key expansion, S-box derived from GF inverse search).
module tb_aes_iter_core;

  typedef logic [3:0][3:0][7:0] blk_t;

  localparam logic [255:0] KeyB   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PtB    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CtB    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KeyC3  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PtC3   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtC3   = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       iv_a, ir_a, ab_a, ov_a, or_a, bsy_a;
  logic [3:0] rki_a;
  blk_t       id_a, rk_a, od_a;
  logic       iv_b, ir_b, ab_b, ov_b, or_b, bsy_b;
  logic [3:0] rki_b;
  blk_t       id_b, rk_b, od_b;

  logic [127:0] rks_a [16];
  logic [127:0] rks_b [16];
  assign rk_a = rks_a[rki_a];
  assign rk_b = rks_b[rki_b];

  aes_iter_core #(.NR(10), .RKI_W(4)) dut_a (
    .clk(clk), .rst(rst_n), .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a), .abort(ab_a),
    .rk_idx(rki_a), .rk(rk_a), .out_valid(ov_a), .out_ready(or_a), .out_data(od_a),
    .busy(bsy_a)
  );

  aes_iter_core #(.NR(14), .RKI_W(4)) dut_b (
    .clk(clk), .rst(rst_n), .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b), .abort(ab_b),
    .rk_idx(rki_b), .rk(rk_b), .out_valid(ov_b), .out_ready(or_b), .out_data(od_b),
    .busy(bsy_b)
  );

  int n_chk = 0;
  int n_pass = 0;
  int idx_q [$];
  logic [7:0] sbox_t [256];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] cst, inv, s;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sbox_t[x] = s;
    end
  endtask

  task automatic load_key(input bit b, input logic [255:0] key, input int nr);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rcon;
    logic [127:0] rkv;
    int           nk;
    nk   = nr - 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon;
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      rkv = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
      if (b) rks_b[r] = rkv;
      else   rks_a[r] = rkv;
    end
  endtask

  // State after the initial key add plus 'stop' rounds; round nr omits MixColumns.
  function automatic logic [127:0] model_enc(input logic [127:0] pt, input int nr,
                                             input int stop, input bit b);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] k, o;
    k = b ? rks_b[0] : rks_a[0];
    for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ k[127-8*n -: 8];
    for (int r = 1; r <= stop; r++) begin
      for (int n = 0; n < 16; n++) t[n] = sbox_t[s[n]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*((c+rr)%4)+rr];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      k = b ? rks_b[r] : rks_a[r];
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ k[127-8*n -: 8];
    end
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = s[n];
    return o;
  endfunction

  // ---------------- drivers (no checking) ----------------
  task automatic send(input bit b, input logic [127:0] pt);
    if (b) begin iv_b = 1'b1; id_b = pt; end
    else   begin iv_a = 1'b1; id_a = pt; end
    @(posedge clk); #1;
    iv_a = 1'b0;
    iv_b = 1'b0;
  endtask

  task automatic wait_valid(input bit b, output int n);
    n = 0;
    idx_q.delete();
    while (!(b ? ov_b : ov_a) && n < 40) begin
      idx_q.push_back(int'(b ? rki_b : rki_a));
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handshake(input bit b);
    if (b) or_b = 1'b1; else or_a = 1'b1;
    @(posedge clk); #1;
    or_a = 1'b0;
    or_b = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    n_chk++; if (ir_a !== 1'b1 || ov_a !== 1'b0 || bsy_a !== 1'b0)
      $display("FAIL reset_ctl: ir=%b ov=%b busy=%b need 1 0 0", ir_a, ov_a, bsy_a);
    else n_pass++;
    n_chk++; if (rki_a !== 4'd0 || rki_b !== 4'd0)
      $display("FAIL reset_rk_idx: a=%0d b=%0d need 0", rki_a, rki_b); else n_pass++;
    n_chk++; if (od_a !== 128'h0 || od_b !== 128'h0)
      $display("FAIL reset_data: a=%h b=%h need 0", od_a, od_b); else n_pass++;
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fips_b();
    int n;
    load_key(1'b0, KeyB, 10);
    n_chk++; if (rki_a !== 4'd0) $display("FAIL b_idle_idx: got %0d need 0", rki_a);
    else n_pass++;
    send(1'b0, PtB);
    wait_valid(1'b0, n);
    n_chk++; if (n != 10) $display("FAIL b_latency: got %0d need 10", n); else n_pass++;
    n_chk++; if (od_a !== CtB) $display("FAIL b_ct: got %h need %h", od_a, CtB); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (i >= idx_q.size() || idx_q[i] != i + 1)
        $display("FAIL b_rk_idx[%0d]: got %0d need %0d", i,
                 (i < idx_q.size()) ? idx_q[i] : -1, i + 1);
      else n_pass++;
    end
    n_chk++; if (ir_a !== 1'b0 || bsy_a !== 1'b0)
      $display("FAIL b_hold_ctl: ir=%b busy=%b need 0 0", ir_a, bsy_a); else n_pass++;
    handshake(1'b0);
    n_chk++; if (ov_a !== 1'b0 || ir_a !== 1'b1)
      $display("FAIL b_after_hs: ov=%b ir=%b need 0 1", ov_a, ir_a); else n_pass++;
`ifdef AES_ZEROIZE_EN
    n_chk++; if (od_a !== 128'h0) $display("FAIL b_zeroize: got %h need 0", od_a);
    else n_pass++;
`else
    n_chk++; if (od_a !== CtB) $display("FAIL b_stale: got %h need %h", od_a, CtB);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    int n;
    logic [255:0] key;
    logic [127:0] pt, exp;
    for (int it = 0; it < 4; it++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      load_key(1'b0, key, 10);
      exp = model_enc(pt, 10, 10, 1'b0);
      send(1'b0, pt);
      wait_valid(1'b0, n);
      n_chk++; if (n != 10 || od_a !== exp)
        $display("FAIL rand%0d: lat=%0d ct=%h need lat=10 ct=%h", it, n, od_a, exp);
      else n_pass++;
      handshake(1'b0);
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [127:0] pt, exp;
    load_key(1'b0, KeyB, 10);
    pt  = {$urandom, $urandom, $urandom, $urandom};
    exp = model_enc(pt, 10, 10, 1'b0);
    send(1'b0, pt);
    wait_valid(1'b0, n);
    for (int c = 0; c < 5; c++) begin
      iv_a = 1'b1;
      id_a = {$urandom, $urandom, $urandom, $urandom};
      n_chk++; if (od_a !== exp || ir_a !== 1'b0 || ov_a !== 1'b1)
        $display("FAIL bp_hold%0d: ct=%h ir=%b ov=%b need ct=%h ir=0 ov=1",
                 c, od_a, ir_a, ov_a, exp);
      else n_pass++;
      @(posedge clk); #1;
    end
    iv_a = 1'b0;
    n_chk++; if (od_a !== exp || ov_a !== 1'b1)
      $display("FAIL bp_end: ct=%h ov=%b need %h 1", od_a, ov_a, exp); else n_pass++;
    handshake(1'b0);
    n_chk++; if (ov_a !== 1'b0 || ir_a !== 1'b1 || bsy_a !== 1'b0)
      $display("FAIL bp_release: ov=%b ir=%b busy=%b need 0 1 0", ov_a, ir_a, bsy_a);
    else n_pass++;
    send(1'b0, PtB);
    n_chk++; if (bsy_a !== 1'b1 || ir_a !== 1'b0)
      $display("FAIL bp_next_accept: busy=%b ir=%b need 1 0", bsy_a, ir_a); else n_pass++;
    wait_valid(1'b0, n);
    n_chk++; if (od_a !== CtB) $display("FAIL bp_next_ct: got %h need %h", od_a, CtB);
    else n_pass++;
    handshake(1'b0);
  endtask

  task automatic test_aes256();
    int n;
    logic [255:0] key;
    logic [127:0] pt, exp;
    load_key(1'b1, KeyC3, 14);
    send(1'b1, PtC3);
    wait_valid(1'b1, n);
    n_chk++; if (n != 14) $display("FAIL c3_latency: got %0d need 14", n); else n_pass++;
    n_chk++; if (od_b !== CtC3) $display("FAIL c3_ct: got %h need %h", od_b, CtC3);
    else n_pass++;
    handshake(1'b1);
    key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    pt  = {$urandom, $urandom, $urandom, $urandom};
    load_key(1'b1, key, 14);
    exp = model_enc(pt, 14, 14, 1'b1);
    send(1'b1, pt);
    wait_valid(1'b1, n);
    n_chk++; if (n != 14 || od_b !== exp)
      $display("FAIL rand256: lat=%0d ct=%h need lat=14 ct=%h", n, od_b, exp);
    else n_pass++;
    handshake(1'b1);
  endtask

  task automatic test_abort();
    int n;
    bit rose;
    logic [127:0] pt, exp;
    load_key(1'b0, KeyB, 10);
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(1'b0, pt);
    repeat (4) begin @(posedge clk); #1; end
    n_chk++; if (rki_a !== 4'd5) $display("FAIL ab_cnt: got %0d need 5", rki_a); else n_pass++;
`ifdef AES_ZEROIZE_EN
    exp = 128'h0;
`else
    exp = model_enc(pt, 10, 4, 1'b0);
`endif
    ab_a = 1'b1;
    @(posedge clk); #1;
    ab_a = 1'b0;
    n_chk++; if (ov_a !== 1'b0 || ir_a !== 1'b1 || bsy_a !== 1'b0 || rki_a !== 4'd0)
      $display("FAIL ab_idle: ov=%b ir=%b busy=%b idx=%0d need 0 1 0 0",
               ov_a, ir_a, bsy_a, rki_a);
    else n_pass++;
    n_chk++; if (od_a !== exp) $display("FAIL ab_data: got %h need %h", od_a, exp);
    else n_pass++;
    rose = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (ov_a) rose = 1'b1; end
    n_chk++; if (rose) $display("FAIL ab_no_valid: out_valid rose=%b need 0", rose);
    else n_pass++;
    // abort together with in_valid in IDLE must not block the accept
    ab_a = 1'b1;
    send(1'b0, PtB);
    ab_a = 1'b0;
    n_chk++; if (bsy_a !== 1'b1) $display("FAIL ab_idle_accept: busy=%b need 1", bsy_a);
    else n_pass++;
    wait_valid(1'b0, n);
    n_chk++; if (n != 10 || od_a !== CtB)
      $display("FAIL ab_rerun: lat=%0d ct=%h need lat=10 ct=%h", n, od_a, CtB);
    else n_pass++;
    ab_a = 1'b1;
    handshake(1'b0);
    ab_a = 1'b0;
`ifdef AES_ZEROIZE_EN
    exp = 128'h0;
`else
    exp = CtB;
`endif
    n_chk++; if (ov_a !== 1'b0 || ir_a !== 1'b1 || od_a !== exp)
      $display("FAIL ab_hold: ov=%b ir=%b ct=%h need 0 1 %h", ov_a, ir_a, od_a, exp);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n;
    load_key(1'b0, KeyB, 10);
    send(1'b0, {$urandom, $urandom, $urandom, $urandom});
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (ov_a !== 1'b0 || ir_a !== 1'b1 || bsy_a !== 1'b0 || rki_a !== 4'd0)
      $display("FAIL rst_mid_ctl: ov=%b ir=%b busy=%b idx=%0d need 0 1 0 0",
               ov_a, ir_a, bsy_a, rki_a);
    else n_pass++;
    n_chk++; if (od_a !== 128'h0) $display("FAIL rst_mid_data: got %h need 0", od_a);
    else n_pass++;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(1'b0, PtB);
    wait_valid(1'b0, n);
    n_chk++; if (n != 10 || od_a !== CtB)
      $display("FAIL rst_mid_rerun: lat=%0d ct=%h need lat=10 ct=%h", n, od_a, CtB);
    else n_pass++;
    handshake(1'b0);
  endtask

  task automatic test_back_to_back();
    int k, kv, acc2, n;
    bit pre, got1;
    logic [127:0] pt2, exp2, ct1;
    load_key(1'b0, KeyB, 10);
    pt2  = {$urandom, $urandom, $urandom, $urandom};
    exp2 = model_enc(pt2, 10, 10, 1'b0);
    or_a = 1'b1;
    iv_a = 1'b1;
    id_a = PtB;
    @(posedge clk); #1;
    id_a = pt2;
    k = 0; kv = -1; acc2 = -1; got1 = 1'b0; ct1 = '0;
    while (k < 40) begin
      pre = ir_a;
      @(posedge clk); #1;
      k++;
      if (ov_a && !got1) begin got1 = 1'b1; kv = k; ct1 = od_a; end
      if (pre) begin acc2 = k; break; end
    end
    iv_a = 1'b0;
    n_chk++; if (kv != 10 || ct1 !== CtB)
      $display("FAIL b2b_first: lat=%0d ct=%h need lat=10 ct=%h", kv, ct1, CtB);
    else n_pass++;
    // HOLD handshake edge, then one IDLE cycle before the next accepting edge
    n_chk++; if (acc2 != 12) $display("FAIL b2b_accept_gap: got %0d need 12", acc2);
    else n_pass++;
    wait_valid(1'b0, n);
    n_chk++; if (n != 10 || od_a !== exp2)
      $display("FAIL b2b_second: lat=%0d ct=%h need lat=10 ct=%h", n, od_a, exp2);
    else n_pass++;
    @(posedge clk); #1;
    or_a = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    iv_a = 1'b0; ab_a = 1'b0; or_a = 1'b0; id_a = '0;
    iv_b = 1'b0; ab_b = 1'b0; or_b = 1'b0; id_b = '0;
    for (int i = 0; i < 16; i++) begin rks_a[i] = '0; rks_b[i] = '0; end
    build_sbox();
    test_reset();
    test_fips_b();
    test_random();
    test_backpressure();
    test_aes256();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
